// File: rtl/dmem_port_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares one single-port synchronous data RAM between three requesters:
//   - CPU load/store path     (fixed priority over the other two)
//   - video fetch path        (read-only; starvation counter forces a slot)
//   - keyboard loader         (round-robin with video)
//
// At most one requester is granted per cycle. The RAM command is a mux of the
// winner's fields, and read data is returned one cycle later together with a
// one-hot owner tag (*_rvalid).
//
// Ports
//   CLK, reset                  clock, synchronous active-high reset
//   cpu_req/we/adr/wd -> cpu_gnt, cpu_rvalid
//   vid_req/adr       -> vid_gnt, vid_rvalid
//   kb_req/we/adr/wd  -> kb_gnt,  kb_rvalid
//   rdata                       read return (pass-through of mem_rd)
//   mem_en/we/adr/wd            RAM command, mem_rd RAM read data
// ----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    // Consecutive denied video cycles after which video outranks CPU (1..15)
    parameter int unsigned VID_STARVE = 4
) (
    input  logic          CLK,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_wd,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,

    input  logic          vid_req,
    input  logic [AW-1:0] vid_adr,
    output logic          vid_gnt,
    output logic          vid_rvalid,

    input  logic          kb_req,
    input  logic          kb_we,
    input  logic [AW-1:0] kb_adr,
    input  logic [DW-1:0] kb_wd,
    output logic          kb_gnt,
    output logic          kb_rvalid,

    output logic [DW-1:0] rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    // Which of video/keyboard was served last in the round-robin pair.
    typedef enum logic {
        RrVid = 1'b0,
        RrKb  = 1'b1
    } rr_e;

    localparam logic [3:0] StarveLimit = 4'(VID_STARVE);

    logic [3:0] vid_wait_q, vid_wait_d;
    rr_e        rr_last_q,  rr_last_d;
    // Read owner one-hot: [0] cpu, [1] vid, [2] kb
    logic [2:0] owner_q,    owner_d;

    logic       vid_starved;
    logic       cpu_win, vid_win, kb_win;

    // ------------------------------------------------------------------------
    // Grant selection. Reset masks every grant so no RAM command escapes
    // during the reset cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        cpu_win     = 1'b0;
        vid_win     = 1'b0;
        kb_win      = 1'b0;
        vid_starved = vid_req && (vid_wait_q == StarveLimit);

        if (!reset) begin
            if (vid_starved) begin
                vid_win = 1'b1;
            end else if (cpu_req) begin
                cpu_win = 1'b1;
            end else if (vid_req && kb_req) begin
                // The contender that was not served last goes first.
                if (rr_last_q == RrKb) begin
                    vid_win = 1'b1;
                end else begin
                    kb_win = 1'b1;
                end
            end else if (vid_req) begin
                vid_win = 1'b1;
            end else if (kb_req) begin
                kb_win = 1'b1;
            end
        end
    end

    assign cpu_gnt = cpu_win;
    assign vid_gnt = vid_win;
    assign kb_gnt  = kb_win;

    // ------------------------------------------------------------------------
    // RAM command mux. Idle bus is driven to zero; video never writes.
    // ------------------------------------------------------------------------
    always_comb begin
        mem_en  = 1'b0;
        mem_we  = 1'b0;
        mem_adr = '0;
        mem_wd  = '0;

        if (cpu_win) begin
            mem_en  = 1'b1;
            mem_we  = cpu_we;
            mem_adr = cpu_adr;
            mem_wd  = cpu_wd;
        end else if (vid_win) begin
            mem_en  = 1'b1;
            mem_adr = vid_adr;
        end else if (kb_win) begin
            mem_en  = 1'b1;
            mem_we  = kb_we;
            mem_adr = kb_adr;
            mem_wd  = kb_wd;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // Starvation counter: counts consecutive denied video cycles and
        // saturates at the limit; any grant or idle cycle clears it.
        vid_wait_d = 4'd0;
        if (vid_req && !vid_win) begin
            if (vid_wait_q >= StarveLimit) begin
                vid_wait_d = StarveLimit;
            end else begin
                vid_wait_d = vid_wait_q + 4'd1;
            end
        end

        // CPU grants leave the round-robin pointer untouched.
        rr_last_d = rr_last_q;
        if (vid_win) begin
            rr_last_d = RrVid;
        end else if (kb_win) begin
            rr_last_d = RrKb;
        end

        // Only reads return data, so writes never tag an owner.
        owner_d = {kb_win & ~kb_we, vid_win, cpu_win & ~cpu_we};
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            vid_wait_q <= 4'd0;
            rr_last_q  <= RrKb;
            owner_q    <= 3'b000;
        end else begin
            vid_wait_q <= vid_wait_d;
            rr_last_q  <= rr_last_d;
            owner_q    <= owner_d;
        end
    end

    // Owner tag is registered, so a read granted just before reset still
    // reports its data in the reset cycle.
    assign cpu_rvalid = owner_q[0];
    assign vid_rvalid = owner_q[1];
    assign kb_rvalid  = owner_q[2];
    assign rdata      = mem_rd;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ----------------------------------------------------------------------------
// Bench for dmem_port_arbiter: a behavioural RAM, a reference model built from
// the arbitration rules (priority, round-robin, starvation limit, one-cycle
// read return), directed scenarios with literal expectations, and a random
// phase with occasional resets.
// ----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int VID_STARVE = 4;

    localparam int NONE = 0;
    localparam int CPU  = 1;
    localparam int VID  = 2;
    localparam int KB   = 3;

    logic          CLK;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_adr;
    logic [DW-1:0] cpu_wd;
    logic          cpu_gnt, cpu_rvalid;
    logic          vid_req;
    logic [AW-1:0] vid_adr;
    logic          vid_gnt, vid_rvalid;
    logic          kb_req, kb_we;
    logic [AW-1:0] kb_adr;
    logic [DW-1:0] kb_wd;
    logic          kb_gnt, kb_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_port_arbiter #(
        .AW         (AW),
        .DW         (DW),
        .VID_STARVE (VID_STARVE)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_adr    (cpu_adr),
        .cpu_wd     (cpu_wd),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .vid_req    (vid_req),
        .vid_adr    (vid_adr),
        .vid_gnt    (vid_gnt),
        .vid_rvalid (vid_rvalid),
        .kb_req     (kb_req),
        .kb_we      (kb_we),
        .kb_adr     (kb_adr),
        .kb_wd      (kb_wd),
        .kb_gnt     (kb_gnt),
        .kb_rvalid  (kb_rvalid),
        .rdata      (rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_adr    (mem_adr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_word(int i);
        logic [7:0] b;
        b = 8'(i);
        if (i == 16) return 32'hDEAD_BEEF;
        return {b, b, b, b} ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural RAM: 256 words, synchronous read, write on the clock edge.
    // ------------------------------------------------------------------------
    logic [31:0] ram [256];
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = init_word(i);
        mem_rd = '0;
        forever begin
            @(posedge CLK);
            if (mem_en) begin
                if (mem_we) ram[mem_adr[7:0]] = mem_wd;
                else        mem_rd <= ram[mem_adr[7:0]];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Reference model + per-cycle compare. Evaluated 2 time units after the
    // falling edge, once the driver has settled this cycle's inputs.
    // ------------------------------------------------------------------------
    int          eg = NONE;       // expected winner of the current cycle
    int          m_wait = 0;      // consecutive denied video cycles
    bit          m_rr_vid = 0;    // 1: video was the last of the pair served
    int          m_owner = NONE;  // owner of the read returning this cycle
    logic [31:0] m_rdata = '0;
    logic [31:0] shadow [256];

    initial begin
        logic          e_we;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_wd;
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        forever begin
            @(negedge CLK);
            #2;
            if (reset)                                  eg = NONE;
            else if (vid_req && m_wait == VID_STARVE)   eg = VID;
            else if (cpu_req)                           eg = CPU;
            else if (vid_req && kb_req)                 eg = m_rr_vid ? KB : VID;
            else if (vid_req)                           eg = VID;
            else if (kb_req)                            eg = KB;
            else                                        eg = NONE;

            e_we = 1'b0; e_adr = '0; e_wd = '0;
            if (eg == CPU) begin e_we = cpu_we; e_adr = cpu_adr; e_wd = cpu_wd; end
            if (eg == VID) begin e_adr = vid_adr; end
            if (eg == KB)  begin e_we = kb_we; e_adr = kb_adr; e_wd = kb_wd; end

            check("grant", {cpu_gnt, vid_gnt, kb_gnt}, {eg == CPU, eg == VID, eg == KB});
            check("mem_cmd", {mem_en, mem_we, mem_adr, mem_wd}, {eg != NONE, e_we, e_adr, e_wd});
            check("rvalid", {cpu_rvalid, vid_rvalid, kb_rvalid},
                  {m_owner == CPU, m_owner == VID, m_owner == KB});
            if (m_owner != NONE) check("rdata", rdata, m_rdata);

            if (reset) begin
                m_wait = 0; m_rr_vid = 0; m_owner = NONE;
            end else begin
                if (vid_req && eg != VID) m_wait = (m_wait < VID_STARVE) ? m_wait + 1 : VID_STARVE;
                else                      m_wait = 0;
                if (eg == VID) m_rr_vid = 1;
                if (eg == KB)  m_rr_vid = 0;
                m_owner = NONE;
                if (eg != NONE) begin
                    if (e_we) shadow[e_adr[7:0]] = e_wd;
                    else begin
                        m_owner = eg;
                        m_rdata = shadow[e_adr[7:0]];
                    end
                end
            end
        end
    end

    task automatic all_idle();
        cpu_req = 0; cpu_we = 0; cpu_adr = '0; cpu_wd = '0;
        vid_req = 0; vid_adr = '0;
        kb_req = 0; kb_we = 0; kb_adr = '0; kb_wd = '0;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus: directed scenarios with literal expectations, then random.
    // ------------------------------------------------------------------------
    initial begin
        logic [3:0] gv, gk, rv, rk;
        logic [9:0] sv, sc;

        reset = 1;
        all_idle();
        cpu_req = 1; cpu_adr = 32'h10;
        vid_req = 1; vid_adr = 32'h20;
        kb_req  = 1; kb_adr  = 32'h30;

        // Reset held with every requester asking: nothing may be granted.
        repeat (2) begin
            @(negedge CLK); #3;
            check("reset_gnt", {cpu_gnt, vid_gnt, kb_gnt}, 3'b000);
            check("reset_mem_en", mem_en, 1'b0);
        end

        // First cycle out of reset: CPU wins, no read data yet.
        @(negedge CLK); reset = 0; #3;
        check("post_reset_cpu_gnt", {cpu_gnt, vid_gnt, kb_gnt}, 3'b100);
        check("post_reset_rvalid", {cpu_rvalid, vid_rvalid, kb_rvalid}, 3'b000);

        // CPU read of 0x10 returns the preloaded word; then video/kb round-robin.
        gv = '0; gk = '0; rv = '0; rk = '0;
        @(negedge CLK); cpu_req = 0; #3;
        check("cpu_rdata", {cpu_rvalid, vid_rvalid, kb_rvalid, rdata}, {3'b100, 32'hDEAD_BEEF});
        gv = {gv[2:0], vid_gnt}; gk = {gk[2:0], kb_gnt};
        repeat (3) begin
            @(negedge CLK); #3;
            gv = {gv[2:0], vid_gnt}; gk = {gk[2:0], kb_gnt};
            rv = {rv[2:0], vid_rvalid}; rk = {rk[2:0], kb_rvalid};
        end
        @(negedge CLK); vid_req = 0; kb_req = 0; #3;
        rv = {rv[2:0], vid_rvalid}; rk = {rk[2:0], kb_rvalid};
        check("rr_vid_gnt", gv, 4'b1010);
        check("rr_kb_gnt", gk, 4'b0101);
        check("rr_vid_rvalid", rv, 4'b1010);
        check("rr_kb_rvalid", rk, 4'b0101);

        // Starvation: CPU and video both held high.
        @(negedge CLK);
        cpu_req = 1; cpu_we = 0; cpu_adr = 32'h44;
        vid_req = 1; vid_adr = 32'h55;
        sv = '0; sc = '0;
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge CLK);
            #3;
            sv = {sv[8:0], vid_gnt}; sc = {sc[8:0], cpu_gnt};
        end
        check("starve_vid_pattern", sv, 10'b0000100001);
        check("starve_cpu_pattern", sc, 10'b1111011110);
        @(negedge CLK); all_idle();

        // Keyboard write then CPU read of the same address.
        @(negedge CLK);
        kb_req = 1; kb_we = 1; kb_adr = 32'h40; kb_wd = 32'h0000_0022; #3;
        check("wr_kb_gnt", {kb_gnt, mem_we, mem_en}, 3'b111);
        @(negedge CLK);
        all_idle(); cpu_req = 1; cpu_adr = 32'h40; #3;
        check("rd_cpu_gnt", {cpu_gnt, mem_we}, 2'b10);
        @(negedge CLK); all_idle(); #3;
        check("wr_rd_data", {cpu_rvalid, kb_rvalid, rdata}, {2'b10, 32'h0000_0022});

        // Reset right after a video read grant.
        @(negedge CLK); vid_req = 1; vid_adr = 32'h50; #3;
        check("mid_vid_gnt", vid_gnt, 1'b1);
        @(negedge CLK); all_idle(); reset = 1; cpu_req = 1; #3;
        check("mid_rvalid_kept", {cpu_rvalid, vid_rvalid, kb_rvalid, rdata},
              {3'b010, init_word(8'h50)});
        check("mid_masked", {cpu_gnt, mem_en}, 2'b00);
        @(negedge CLK); reset = 0; cpu_req = 0; vid_req = 1; kb_req = 1; #3;
        check("mid_rvalid_cleared", {cpu_rvalid, vid_rvalid, kb_rvalid}, 3'b000);
        check("mid_rr_reset", {vid_gnt, kb_gnt}, 2'b10);
        @(negedge CLK); vid_req = 0; #3;
        check("mid_kb_next", kb_gnt, 1'b1);
        @(negedge CLK); all_idle();

        // Random traffic; a requester only changes its command once served.
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            reset = ($urandom_range(0, 99) == 0);
            if (!cpu_req || eg == CPU) begin
                cpu_req = ($urandom_range(0, 1) == 1);
                cpu_we  = ($urandom_range(0, 2) == 0);
                cpu_adr = 32'($urandom_range(0, 255));
                cpu_wd  = $urandom;
            end
            if (!vid_req || eg == VID) begin
                vid_req = ($urandom_range(0, 1) == 1);
                vid_adr = 32'($urandom_range(0, 255));
            end
            if (!kb_req || eg == KB) begin
                kb_req = ($urandom_range(0, 1) == 1);
                kb_we  = ($urandom_range(0, 1) == 1);
                kb_adr = 32'($urandom_range(0, 255));
                kb_wd  = $urandom;
            end
        end

        @(negedge CLK); all_idle(); reset = 0;
        repeat (2) @(negedge CLK);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
